multi_irq_controller: RTL and testbench
=======================================

Name: multi_irq_controller

Overview:
- Parametrised successor to the CPU's single-IRQ/NMI interrupt logic.
- Accepts NUM_IRQ external IRQ sources (per-source level or edge mode), an NMI line, and a per-source enable mask.
- Produces pending/perform-interrupt flags, highest-priority source ID, and a latched vector select (RESET/NMI/IRQ-BRK) with NMI hijack.
- Sits between cartridge/APU/mapper interrupt sources and the 6502 core's sequencer; single clock domain.

Parameters:
- NUM_IRQ, 4, number of IRQ sources (1..16); index 0 has highest priority.
- EDGE_MASK, {NUM_IRQ{1'b0}}, bit i = 1 makes source i falling-edge sensitive; 0 = level (active-low).
- SYNC_STAGES, 2, synchroniser flops on irq_n/nmi_n (0..3; 0 = no synchroniser).
- ID_W, $clog2(NUM_IRQ) min 1, width of irq_id.

Ports:
- clk_ph1  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_n  in  NUM_IRQ  external IRQ lines, active low.
- nmi_n  in  1  NMI line, active low, falling-edge sensitive.
- irq_mask  in  1  CPU I flag; 1 blocks all IRQs (not NMI).
- en_we  in  1  write strobe for enable mask.
- en_wdata  in  NUM_IRQ  new enable mask.
- src_clr  in  NUM_IRQ  per-source clear of edge-latched pending bit (ignored for level sources).
- poll  in  1  CPU at an interrupt poll point (last cycle of instruction, branch poll cycle); core excludes BRK.
- int_ack  in  1  CPU has entered the interrupt/reset sequence.
- vec_fetch  in  1  CPU in vector-low fetch cycle; locks vector.
- irq_pending  out  NUM_IRQ  registered per-source pending (before enable/mask).
- irq_id  out  ID_W  lowest index with pending & enable; 0 when none.
- irq_id_valid  out  1  any pending & enable.
- irq_out  out  1  registered IRQ-detected flag.
- nmi_out  out  1  registered NMI-detected flag.
- int_out  out  1  perform-interrupt request to sequencer.
- vec_sel  out  2  2'b10 RESET ($FFFC), 2'b01 NMI ($FFFA), 2'b00 IRQ/BRK ($FFFE).

Behaviour:
- Reset (rst=1 at edge): enable mask=all ones, irq_pending=0, edge latches=0, nmi_det=0, nmi_out=0, irq_out=0, int_out=1, reset_flag=1, vec_sel=2'b10, sync chains and prev-value regs loaded with 1 (inactive). Reset mid-sequence discards everything, including a pending NMI.
- Sync: irq_n/nmi_n pass SYNC_STAGES flops; line first sampled low at edge k is seen by detection logic at edge k+SYNC_STAGES.
- Level source i: irq_pending[i] <= !irq_s[i] every cycle.
- Edge source i: set on synchronised 1->0; held until src_clr[i]; simultaneous set and clear -> set wins.
- Enable: en_we loads mask at the edge; pending bits unaffected.
- irq_det = |(irq_pending & en) & !irq_mask; irq_out <= irq_det (one cycle after pending).
- nmi_det: set on synchronised nmi 1->0; cleared at vec_fetch when latched vec_sel=NMI; set wins over clear in same cycle. nmi_out <= nmi_det.
- int_out priority: rst -> 1; else int_ack -> 0; else poll & (irq_out|nmi_out) -> 1; else hold. Poll with both flags low leaves int_out unchanged.
- Vector (combinational until locked): reset_flag ? RESET : nmi_out ? NMI : IRQ. At vec_fetch, vec_sel register captures this and holds until next vec_fetch or rst.
- At vec_fetch: reset_flag cleared; NMI selected clears nmi_det. An NMI after int_ack but before vec_fetch hijacks an IRQ/BRK sequence.
- irq_id: priority encoder on pending & en, combinational from registers; irq_id=0 and irq_id_valid=0 when empty.
- IRQ dropping before poll is not latched (level, 6502-accurate); edge sources stay pending until cleared.

Test Plan:
- Reset: rst=1 two cycles, release -> int_out=1, vec_sel=2'b10. int_ack then vec_fetch -> int_out=0, vec_sel stays 2'b10, reset_flag cleared. Next vec_fetch with nothing pending -> vec_sel=2'b00.
- Level IRQ, SYNC_STAGES=2: irq_n[2] low at edge k -> irq_pending[2]=1 after edge k+2, irq_out=1 after edge k+3. poll at k+4 -> int_out=1, irq_id=2. Repeat with irq_mask=1 -> irq_out stays 0, int_out stays 0.
- Priority/enable: sources 1 and 3 pending -> irq_id=1. en_wdata=4'b1101 -> irq_id=3. en_wdata=0 -> irq_id_valid=0, irq_out=0.
- Edge source (EDGE_MASK=4'b0001): 1-cycle low pulse on irq_n[0] -> pending stays 1 after release. src_clr[0] and a new falling edge in the same cycle -> pending remains 1.
- NMI hijack: IRQ taken, int_ack, nmi_n falls before vec_fetch -> vec_sel latches 2'b01, nmi_out clears after vec_fetch. NMI held low for 10 cycles -> exactly one detection.
- Reset mid-operation: nmi_det=1 and int_out=1, assert rst -> all flags cleared except int_out=1, vec_sel=2'b10.

Source files
------------

// File: rtl/multi_irq_controller_if.sv
// multi_irq_controller_if: CPU-side interrupt request/ack bundle
// master: CPU sequencer / sources drive requests, read detection results
// slave:  controller reads requests, drives pending/id/flags/vector
interface multi_irq_controller_if #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
);
    logic [NUM_IRQ-1:0] irq_n;
    logic               nmi_n;
    logic               irq_mask;
    logic               en_we;
    logic [NUM_IRQ-1:0] en_wdata;
    logic [NUM_IRQ-1:0] src_clr;
    logic               poll;
    logic               int_ack;
    logic               vec_fetch;
    logic [NUM_IRQ-1:0] irq_pending;
    logic [ID_W-1:0]    irq_id;
    logic               irq_id_valid;
    logic               irq_out;
    logic               nmi_out;
    logic               int_out;
    logic [1:0]         vec_sel;
    modport master (
        output irq_n, nmi_n, irq_mask, en_we, en_wdata, src_clr, poll, int_ack, vec_fetch,
        input  irq_pending, irq_id, irq_id_valid, irq_out, nmi_out, int_out, vec_sel
    );
    modport slave (
        input  irq_n, nmi_n, irq_mask, en_we, en_wdata, src_clr, poll, int_ack, vec_fetch,
        output irq_pending, irq_id, irq_id_valid, irq_out, nmi_out, int_out, vec_sel
    );
endinterface

// File: rtl/multi_irq_controller.sv
// multi_irq_controller: multi-source IRQ + NMI detection and vector select for the 6502 core
// clk_ph1/rst: sole clock, synchronous active-high reset
// bus (slave): irq_n/nmi_n lines, irq_mask, enable write, src_clr, poll/int_ack/vec_fetch in;
//              irq_pending, irq_id(_valid), irq_out, nmi_out, int_out, vec_sel out
module multi_irq_controller #(
    parameter int                 NUM_IRQ     = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 ID_W        = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
    input logic clk_ph1,
    input logic rst,
    multi_irq_controller_if.slave bus
);
    logic [NUM_IRQ:0]   raw, s, prev, fall;
    logic [NUM_IRQ-1:0] en, pending, act;
    logic               nmi_det, reset_flag;
    logic [1:0]         vec_now;
    // bit NUM_IRQ carries nmi_n through the same synchroniser as the IRQ lines
    assign raw = {bus.nmi_n, bus.irq_n};
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = raw;
        end else begin : g_sync
            logic [NUM_IRQ:0] chain [SYNC_STAGES];
            always_ff @(posedge clk_ph1) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '1;
                end else begin
                    chain[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate
    assign fall    = prev & ~s;
    assign act     = pending & en;
    assign vec_now = reset_flag ? 2'b10 : bus.nmi_out ? 2'b01 : 2'b00;
    assign bus.irq_pending  = pending;
    assign bus.irq_id_valid = |act;
    always_comb begin
        bus.irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (act[i]) bus.irq_id = ID_W'(i);
    end
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            prev        <= '1;
            en          <= '1;
            pending     <= '0;
            nmi_det     <= 1'b0;
            reset_flag  <= 1'b1;
            bus.irq_out <= 1'b0;
            bus.nmi_out <= 1'b0;
            bus.int_out <= 1'b1;
            bus.vec_sel <= 2'b10;
        end else begin
            prev        <= s;
            // edge sources: set on fall, hold until cleared, set beats clear; level sources track the line
            pending     <= (EDGE_MASK & (fall[NUM_IRQ-1:0] | (pending & ~bus.src_clr)))
                         | (~EDGE_MASK & ~s[NUM_IRQ-1:0]);
            if (bus.en_we) en <= bus.en_wdata;
            bus.irq_out <= (|act) & ~bus.irq_mask;
            nmi_det     <= fall[NUM_IRQ] | (nmi_det & ~(bus.vec_fetch & (vec_now == 2'b01)));
            bus.nmi_out <= nmi_det;
            bus.int_out <= bus.int_ack ? 1'b0 : (bus.poll & (bus.irq_out | bus.nmi_out)) | bus.int_out;
            if (bus.vec_fetch) begin
                bus.vec_sel <= vec_now;
                reset_flag  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_irq_controller.sv
// tb_multi_irq_controller: directed checks of reset, level/edge IRQ, priority, NMI hijack, mid-run reset
module tb_multi_irq_controller;
    logic clk_ph1 = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    multi_irq_controller_if #(.NUM_IRQ(4)) bus ();
    multi_irq_controller #(.NUM_IRQ(4), .EDGE_MASK(4'b0001), .SYNC_STAGES(2)) dut (
        .clk_ph1(clk_ph1),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk_ph1 = ~clk_ph1;
    task automatic tick(input int n);
        repeat (n) @(posedge clk_ph1);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    initial begin
        bus.irq_n = 4'hF;
        bus.nmi_n = 1'b1;
        bus.irq_mask = 1'b0;
        bus.en_we = 1'b0;
        bus.en_wdata = 4'h0;
        bus.src_clr = 4'h0;
        bus.poll = 1'b0;
        bus.int_ack = 1'b0;
        bus.vec_fetch = 1'b0;
        tick(2);
        chk("rst_int_out", 32'(bus.int_out), 1);
        chk("rst_vec_sel", 32'(bus.vec_sel), 2);
        chk("rst_irq_out", 32'(bus.irq_out), 0);
        chk("rst_nmi_out", 32'(bus.nmi_out), 0);
        chk("rst_pending", 32'(bus.irq_pending), 0);
        chk("rst_id_valid", 32'(bus.irq_id_valid), 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_int_out", 32'(bus.int_out), 1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("ack_int_out", 32'(bus.int_out), 0);
        bus.vec_fetch = 1'b1;
        tick(1);
        chk("vf1_vec_sel", 32'(bus.vec_sel), 2);
        tick(1);
        bus.vec_fetch = 1'b0;
        chk("vf2_vec_sel", 32'(bus.vec_sel), 0);
        // level IRQ on source 2
        bus.irq_n = 4'b1011;
        tick(2);
        chk("lvl_k1_pending", 32'(bus.irq_pending), 0);
        tick(1);
        chk("lvl_k2_pending", 32'(bus.irq_pending), 4'b0100);
        chk("lvl_k2_irq_out", 32'(bus.irq_out), 0);
        tick(1);
        chk("lvl_k3_irq_out", 32'(bus.irq_out), 1);
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        chk("lvl_int_out", 32'(bus.int_out), 1);
        chk("lvl_irq_id", 32'(bus.irq_id), 2);
        bus.irq_n = 4'hF;
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("lvl_ack", 32'(bus.int_out), 0);
        tick(4);
        chk("lvl_release_pending", 32'(bus.irq_pending), 0);
        chk("lvl_release_irq_out", 32'(bus.irq_out), 0);
        // same source with I flag set
        bus.irq_mask = 1'b1;
        bus.irq_n = 4'b1011;
        tick(4);
        chk("mask_pending", 32'(bus.irq_pending), 4'b0100);
        chk("mask_irq_out", 32'(bus.irq_out), 0);
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        chk("mask_int_out", 32'(bus.int_out), 0);
        bus.irq_mask = 1'b0;
        // priority and enable mask with sources 1 and 3
        bus.irq_n = 4'b0101;
        tick(3);
        chk("prio_pending", 32'(bus.irq_pending), 4'b1010);
        chk("prio_id", 32'(bus.irq_id), 1);
        bus.en_we = 1'b1;
        bus.en_wdata = 4'b1101;
        tick(1);
        chk("en1101_id", 32'(bus.irq_id), 3);
        chk("en1101_pending", 32'(bus.irq_pending), 4'b1010);
        bus.en_wdata = 4'b0000;
        tick(1);
        bus.en_we = 1'b0;
        chk("en0_valid", 32'(bus.irq_id_valid), 0);
        chk("en0_id", 32'(bus.irq_id), 0);
        tick(1);
        chk("en0_irq_out", 32'(bus.irq_out), 0);
        bus.en_we = 1'b1;
        bus.en_wdata = 4'hF;
        bus.irq_n = 4'hF;
        tick(1);
        bus.en_we = 1'b0;
        tick(4);
        chk("idle_pending", 32'(bus.irq_pending), 0);
        // edge-mode source 0
        bus.irq_n = 4'b1110;
        tick(1);
        bus.irq_n = 4'hF;
        tick(2);
        chk("edge_set", 32'(bus.irq_pending), 4'b0001);
        tick(3);
        chk("edge_hold", 32'(bus.irq_pending), 4'b0001);
        chk("edge_id_valid", 32'(bus.irq_id_valid), 1);
        bus.irq_n = 4'b1110;
        tick(1);
        bus.irq_n = 4'hF;
        tick(1);
        bus.src_clr = 4'b0001;
        tick(1);
        chk("edge_set_beats_clr", 32'(bus.irq_pending), 4'b0001);
        tick(1);
        bus.src_clr = 4'b0000;
        chk("edge_cleared", 32'(bus.irq_pending), 0);
        tick(1);
        chk("edge_cleared_irq_out", 32'(bus.irq_out), 0);
        // NMI hijacks an IRQ sequence between int_ack and vec_fetch
        bus.irq_n = 4'b1101;
        tick(4);
        chk("hj_irq_out", 32'(bus.irq_out), 1);
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        chk("hj_int_out", 32'(bus.int_out), 1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("hj_ack", 32'(bus.int_out), 0);
        bus.nmi_n = 1'b0;
        tick(3);
        chk("hj_nmi_out_early", 32'(bus.nmi_out), 0);
        tick(1);
        chk("hj_nmi_out", 32'(bus.nmi_out), 1);
        bus.vec_fetch = 1'b1;
        tick(1);
        bus.vec_fetch = 1'b0;
        chk("hj_vec_sel", 32'(bus.vec_sel), 1);
        tick(1);
        chk("hj_nmi_out_cleared", 32'(bus.nmi_out), 0);
        tick(6);
        chk("hj_single_detect", 32'(bus.nmi_out), 0);
        chk("hj_vec_hold", 32'(bus.vec_sel), 1);
        bus.nmi_n = 1'b1;
        bus.irq_n = 4'hF;
        tick(4);
        // reset in the middle of a pending NMI
        bus.nmi_n = 1'b0;
        tick(4);
        chk("mr_nmi_out", 32'(bus.nmi_out), 1);
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        chk("mr_int_out", 32'(bus.int_out), 1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        chk("mr_int_out_again", 32'(bus.int_out), 1);
        rst = 1'b1;
        bus.nmi_n = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mr_nmi_out_cleared", 32'(bus.nmi_out), 0);
        chk("mr_irq_out", 32'(bus.irq_out), 0);
        chk("mr_int_out_set", 32'(bus.int_out), 1);
        chk("mr_vec_sel", 32'(bus.vec_sel), 2);
        tick(4);
        chk("mr_nmi_discarded", 32'(bus.nmi_out), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
